regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 108 ++++++++++
 tb/tb_regfile_scoreboard.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy bits for destination reservation.
// Two combinational read ports with write-through bypass, one write-back
// port, and one reservation port. BusyCount is the registered population
// count of the busy bits and moves in the same cycle as the busy bits.
//
// Reservation handshake: RsvEn is a request and RsvAck is a same-cycle
// combinational grant. A request is granted when the target register is
// not busy, or when the same cycle writes that register back. A granted
// request marks the register busy at the next rising edge. There is no
// back-pressure on the write-back port: WrEn is always accepted.
module regfile_scoreboard #(
  parameter int DATA_W   = 13,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] RdAddrA,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic [DATA_W-1:0] RdDataA,
  output logic [DATA_W-1:0] RdDataB,
  output logic              RdBusyA,
  output logic              RdBusyB,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  input  logic              RsvEn,
  input  logic [ADDR_W-1:0] RsvAddr,
  output logic              RsvAck,
  output logic [ADDR_W:0]   BusyCount
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [CW-1:0]     busy_count_q;
  logic [CW-1:0]     busy_count_nxt;

  // Reset overrides the write port, so every write-driven path uses wr_eff.
  logic wr_eff;
  logic wr_live;
  logic wr_zero;
  logic rsv_zero;
  logic rd_zero_a;
  logic rd_zero_b;
  logic hit_a;
  logic hit_b;

  assign wr_eff    = WrEn & ~Reset;
  assign wr_zero   = (ZERO_REG != 0) && (WrAddr == '0);
  assign rsv_zero  = (ZERO_REG != 0) && (RsvAddr == '0);
  assign rd_zero_a = (ZERO_REG != 0) && (RdAddrA == '0);
  assign rd_zero_b = (ZERO_REG != 0) && (RdAddrB == '0);
  assign wr_live   = wr_eff & ~wr_zero;
  assign hit_a     = wr_eff && (WrAddr == RdAddrA);
  assign hit_b     = wr_eff && (WrAddr == RdAddrB);

  // A hard-wired zero register is always grantable and never becomes busy.
  assign RsvAck = ~Reset & RsvEn &
                  (rsv_zero | ~busy[RsvAddr] | (wr_eff && (WrAddr == RsvAddr)));

  assign RdDataA = rd_zero_a ? '0 : (hit_a ? WrData : regs[RdAddrA]);
  assign RdDataB = rd_zero_b ? '0 : (hit_b ? WrData : regs[RdAddrB]);
  assign RdBusyA = ~rd_zero_a & busy[RdAddrA] & ~hit_a;
  assign RdBusyB = ~rd_zero_b & busy[RdAddrB] & ~hit_b;

  assign BusyCount = busy_count_q;

  // Next busy vector: write-back clears first, a granted reservation then sets.
  always_comb begin
    busy_nxt = busy;
    if (wr_live) begin
      busy_nxt[WrAddr] = 1'b0;
    end
    if (RsvAck && !rsv_zero) begin
      busy_nxt[RsvAddr] = 1'b1;
    end
  end

  // Population count of the next busy vector, registered alongside it.
  always_comb begin
    busy_count_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_count_nxt = busy_count_nxt + CW'(busy_nxt[i]);
    end
  end

  // Register array, busy bits and busy count; reset clears everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy         <= '0;
      busy_count_q <= '0;
    end else begin
      if (wr_live) begin
        regs[WrAddr] <= WrData;
      end
      busy         <= busy_nxt;
      busy_count_q <= busy_count_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: one instance with a normal register 0 and
// one with a hard-wired zero register, sharing all inputs. A register/busy
// array model predicts every output before each rising edge.
module tb_regfile_scoreboard;

  localparam int DW = 13;
  localparam int AW = 3;
  localparam int D  = 8;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en, rsv_en;

  logic [DW-1:0] rd_data_a [2];
  logic [DW-1:0] rd_data_b [2];
  logic          rd_busy_a [2];
  logic          rd_busy_b [2];
  logic          rsv_ack   [2];
  logic [AW:0]   busy_count[2];

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut0 (
    .Clk(clk), .Reset(reset),
    .RdAddrA(rd_addr_a), .RdAddrB(rd_addr_b),
    .RdDataA(rd_data_a[0]), .RdDataB(rd_data_b[0]),
    .RdBusyA(rd_busy_a[0]), .RdBusyB(rd_busy_b[0]),
    .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
    .RsvEn(rsv_en), .RsvAddr(rsv_addr), .RsvAck(rsv_ack[0]),
    .BusyCount(busy_count[0])
  );

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut1 (
    .Clk(clk), .Reset(reset),
    .RdAddrA(rd_addr_a), .RdAddrB(rd_addr_b),
    .RdDataA(rd_data_a[1]), .RdDataB(rd_data_b[1]),
    .RdBusyA(rd_busy_a[1]), .RdBusyB(rd_busy_b[1]),
    .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
    .RsvEn(rsv_en), .RsvAddr(rsv_addr), .RsvAck(rsv_ack[1]),
    .BusyCount(busy_count[1])
  );

  // Reference model: index k = 1 is the zero-register variant
  logic [DW-1:0] m_reg  [2][D];
  logic          m_busy [2][D];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s z%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic is_zero(input int k, input logic [AW-1:0] a);
    return (k == 1) && (a == 0);
  endfunction

  function automatic logic writing(input logic [AW-1:0] a);
    return !reset && wr_en && (wr_addr == a);
  endfunction

  function automatic logic [DW-1:0] exp_data(input int k, input logic [AW-1:0] a);
    if (is_zero(k, a)) return '0;
    if (writing(a)) return wr_data;
    return m_reg[k][a];
  endfunction

  function automatic logic exp_busy(input int k, input logic [AW-1:0] a);
    if (is_zero(k, a)) return 1'b0;
    return m_busy[k][a] && !writing(a);
  endfunction

  function automatic logic exp_ack(input int k);
    if (reset || !rsv_en) return 1'b0;
    return is_zero(k, rsv_addr) || !m_busy[k][rsv_addr] || writing(rsv_addr);
  endfunction

  function automatic int exp_count(input int k);
    int n = 0;
    for (int i = 0; i < D; i++) n += int'(m_busy[k][i]);
    return n;
  endfunction

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      chk("rd_data_a", k, 32'(rd_data_a[k]), 32'(exp_data(k, rd_addr_a)));
      chk("rd_data_b", k, 32'(rd_data_b[k]), 32'(exp_data(k, rd_addr_b)));
      chk("rd_busy_a", k, 32'(rd_busy_a[k]), 32'(exp_busy(k, rd_addr_a)));
      chk("rd_busy_b", k, 32'(rd_busy_b[k]), 32'(exp_busy(k, rd_addr_b)));
      chk("rsv_ack",   k, 32'(rsv_ack[k]),   32'(exp_ack(k)));
      chk("busy_count", k, 32'(busy_count[k]), 32'(exp_count(k)));
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < D; i++) begin
        m_reg[k][i]  = '0;
        m_busy[k][i] = 1'b0;
      end
  endtask

  // Apply one rising edge to the model using the inputs held across it
  task automatic model_edge();
    logic ack;
    if (reset) begin
      model_clear();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      ack = exp_ack(k);
      if (wr_en && !is_zero(k, wr_addr)) begin
        m_reg[k][wr_addr]  = wr_data;
        m_busy[k][wr_addr] = 1'b0;
      end
      if (ack && !is_zero(k, rsv_addr)) m_busy[k][rsv_addr] = 1'b1;
    end
  endtask

  // Driver tasks: inputs change just after the falling edge
  task automatic idle();
    reset = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
    wr_addr = '0; wr_data = '0; rsv_addr = '0;
  endtask

  task automatic cycle();
    #2;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    rsv_en = 1'b1; rsv_addr = a;
  endtask

  initial begin
    idle();
    rd_addr_a = '0; rd_addr_b = '0;
    reset = 1'b1;
    @(negedge clk);
    @(posedge clk);
    model_clear();
    @(negedge clk);

    // Reset cycle with a reservation request: no grant, all outputs zero
    reset = 1'b1; rsv(3'd1);
    cycle();
    idle();

    // Write r5, read back next cycle
    wr(3'd5, 13'h1ABC);
    cycle();
    idle(); rd_addr_a = 3'd5;
    #1;
    chk("r5_readback", 0, 32'(rd_data_a[0]), 32'h1ABC);
    chk("r5_not_busy", 0, 32'(rd_busy_a[0]), 32'h0);
    cycle();

    // Same-cycle bypass on port B
    wr(3'd3, 13'h0042); rd_addr_b = 3'd3;
    #1;
    chk("r3_bypass", 0, 32'(rd_data_b[0]), 32'h0042);
    cycle();
    idle();

    // Reserve r2, re-reserve refused, write-back releases
    rsv(3'd2); rd_addr_a = 3'd2;
    #1;
    chk("rsv_r2_ack", 0, 32'(rsv_ack[0]), 32'h1);
    cycle();
    idle();
    #1;
    chk("r2_busy", 0, 32'(rd_busy_a[0]), 32'h1);
    chk("count_1", 0, 32'(busy_count[0]), 32'h1);
    rsv(3'd2);
    #1;
    chk("rsv_r2_refused", 0, 32'(rsv_ack[0]), 32'h0);
    cycle();
    idle(); wr(3'd2, 13'h0123);
    #1;
    chk("r2_release_same_cycle", 0, 32'(rd_busy_a[0]), 32'h0);
    cycle();
    idle();
    #1;
    chk("count_0", 0, 32'(busy_count[0]), 32'h0);
    cycle();

    // r4 busy, then simultaneous write-back and re-reservation
    rsv(3'd4);
    cycle();
    idle(); wr(3'd4, 13'd7); rsv(3'd4); rd_addr_a = 3'd4;
    #1;
    chk("r4_rsv_with_wb_ack", 0, 32'(rsv_ack[0]), 32'h1);
    cycle();
    idle();
    #1;
    chk("r4_data", 0, 32'(rd_data_a[0]), 32'd7);
    chk("r4_still_busy", 0, 32'(rd_busy_a[0]), 32'h1);
    chk("r4_count", 0, 32'(busy_count[0]), 32'h1);
    cycle();

    // Reserve every register, then reset alongside a write to r1
    for (int i = 0; i < D; i++) begin
      idle(); rsv(AW'(i));
      cycle();
    end
    idle();
    #1;
    chk("count_full", 0, 32'(busy_count[0]), 32'd8);
    chk("count_full_zr", 1, 32'(busy_count[1]), 32'd7);
    cycle();
    reset = 1'b1; wr(3'd1, 13'h0AAA); rsv(3'd6); rd_addr_a = 3'd1;
    cycle();
    idle();
    #1;
    chk("r1_after_reset", 0, 32'(rd_data_a[0]), 32'h0);
    chk("count_after_reset", 0, 32'(busy_count[0]), 32'h0);
    cycle();

    // Zero register: write and reserve r0
    wr(3'd0, 13'h1FFF); rsv(3'd0); rd_addr_a = 3'd0;
    #1;
    chk("z_r0_ack", 1, 32'(rsv_ack[1]), 32'h1);
    chk("z_r0_no_bypass", 1, 32'(rd_data_a[1]), 32'h0);
    cycle();
    idle();
    #1;
    chk("z_r0_data", 1, 32'(rd_data_a[1]), 32'h0);
    chk("z_r0_busy", 1, 32'(rd_busy_a[1]), 32'h0);
    chk("z_r0_count", 1, 32'(busy_count[1]), 32'h0);
    chk("r0_written", 0, 32'(rd_data_a[0]), 32'h1FFF);
    cycle();

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 49) == 0);
      wr_en     = $urandom_range(0, 1) == 1;
      wr_addr   = AW'($urandom_range(0, D - 1));
      wr_data   = DW'($urandom);
      rsv_en    = $urandom_range(0, 2) != 0;
      rsv_addr  = AW'($urandom_range(0, D - 1));
      rd_addr_a = AW'($urandom_range(0, D - 1));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : AW'($urandom_range(0, D - 1));
      cycle();
    end
    idle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
